// File: rtl/writeback_queue.sv
// In-order result queue between the ALU/memory stages and the register file write port.
// Drains one entry per clock and exposes a bypass lookup over all uncommitted writes.
module writeback_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Mem_Valid,
  input  logic [ADDR_WIDTH-1:0]   Mem_Register,
  input  logic [DATA_WIDTH-1:0]   Mem_Data,
  output logic                    Mem_Ready,
  input  logic                    Alu_Valid,
  input  logic [ADDR_WIDTH-1:0]   Alu_Register,
  input  logic [DATA_WIDTH-1:0]   Alu_Data,
  output logic                    Alu_Ready,
  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   Write_Register,
  output logic [DATA_WIDTH-1:0]   Write_Data,
  input  logic [ADDR_WIDTH-1:0]   Lookup_Register,
  output logic                    Lookup_Hit,
  output logic [DATA_WIDTH-1:0]   Lookup_Data,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full     = CntW'(DEPTH);
  localparam logic [CntW-1:0] FullLess2 = CntW'(DEPTH - 2);

  logic [ADDR_WIDTH-1:0] entry_reg_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_reg_d  [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_d [DEPTH];

  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d, alu_ptr;
  logic [CntW-1:0]       count_q, count_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  mem_enq, alu_enq, pop;

  // Readies look only at registered occupancy; a same-cycle pop never frees a slot early.
  assign Mem_Ready = (count_q != Full);
  assign Alu_Ready = Mem_Valid ? (count_q <= FullLess2) : (count_q != Full);

  always_comb begin
    // Register 0 transfers complete the handshake but are dropped here.
    mem_enq = Mem_Valid && Mem_Ready && (Mem_Register != '0);
    alu_enq = Alu_Valid && Alu_Ready && (Alu_Register != '0);
    pop     = (count_q != '0);

    alu_ptr = mem_enq ? tail_q + PtrW'(1) : tail_q;
    tail_d  = tail_q + PtrW'(mem_enq) + PtrW'(alu_enq);
    head_d  = pop ? head_q + PtrW'(1) : head_q;
    count_d = count_q + CntW'(mem_enq) + CntW'(alu_enq) - CntW'(pop);

    entry_reg_d  = entry_reg_q;
    entry_data_d = entry_data_q;
    if (mem_enq) begin
      entry_reg_d[tail_q]  = Mem_Register;
      entry_data_d[tail_q] = Mem_Data;
    end
    if (alu_enq) begin
      entry_reg_d[alu_ptr]  = Alu_Register;
      entry_data_d[alu_ptr] = Alu_Data;
    end

    regwrite_d = pop;
    wr_reg_d   = pop ? entry_reg_q[head_q]  : wr_reg_q;
    wr_data_d  = pop ? entry_data_q[head_q] : wr_data_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Storage needs no reset: only slots covered by count_q are ever read.
  always_ff @(posedge Clock) begin
    entry_reg_q  <= entry_reg_d;
    entry_data_q <= entry_data_d;
  end

  always_comb begin
    logic [PtrW-1:0] idx;
    idx         = '0;
    Lookup_Hit  = 1'b0;
    Lookup_Data = '0;
    if (regwrite_q && (wr_reg_q == Lookup_Register)) begin
      Lookup_Hit  = 1'b1;
      Lookup_Data = wr_data_q;
    end
    // Walk oldest to youngest so the entry nearest the tail wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (entry_reg_q[idx] == Lookup_Register)) begin
        Lookup_Hit  = 1'b1;
        Lookup_Data = entry_data_q[idx];
      end
    end
    if (Lookup_Register == '0) begin
      Lookup_Hit  = 1'b0;
      Lookup_Data = '0;
    end
  end

  assign RegWrite       = regwrite_q;
  assign Write_Register = wr_reg_q;
  assign Write_Data     = wr_data_q;
  assign Count          = count_q;
  assign Empty          = (count_q == '0) && !regwrite_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single/dual writes, backpressure, reg 0, reset mid-drain.
module tb_writeback_queue;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Mem_Valid, Alu_Valid, Mem_Ready, Alu_Ready;
  logic [4:0]  Mem_Register, Alu_Register, Write_Register, Lookup_Register;
  logic [31:0] Mem_Data, Alu_Data, Write_Data, Lookup_Data;
  logic        RegWrite, Lookup_Hit, Empty;
  logic [2:0]  Count;

  int passes = 0;
  int total  = 0;

  writeback_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Mem_Valid(Mem_Valid), .Mem_Register(Mem_Register), .Mem_Data(Mem_Data),
    .Mem_Ready(Mem_Ready),
    .Alu_Valid(Alu_Valid), .Alu_Register(Alu_Register), .Alu_Data(Alu_Data),
    .Alu_Ready(Alu_Ready),
    .RegWrite(RegWrite), .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Lookup_Register(Lookup_Register), .Lookup_Hit(Lookup_Hit), .Lookup_Data(Lookup_Data),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Mem_Valid = 1'b0; Mem_Register = '0; Mem_Data = '0;
    Alu_Valid = 1'b0; Alu_Register = '0; Alu_Data = '0;
  endtask

  // Scoreboard state for the backpressure run
  logic [4:0]  q_reg[$];
  logic [31:0] q_data[$];
  int          mcount, m_idx, a_idx;
  logic        exp_rw, macc, aacc;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;

  initial begin
    idle_inputs();
    Lookup_Register = 5'd5;

    // Reset with both sources asserting valid
    Reset_n = 1'b0;
    Mem_Valid = 1'b1; Mem_Register = 5'd5; Mem_Data = 32'h55;
    Alu_Valid = 1'b1; Alu_Register = 5'd6; Alu_Data = 32'h66;
    tick();
    tick();
    Reset_n = 1'b1;
    idle_inputs();
    #1;
    chk("rst_count", Count, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", Write_Register, 0);
    chk("rst_wdata", Write_Data, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_mem_ready", Mem_Ready, 1);
    chk("rst_alu_ready", Alu_Ready, 1);
    chk("rst_lookup_hit", Lookup_Hit, 0);
    chk("rst_lookup_data", Lookup_Data, 0);
    tick();
    chk("idle_count", Count, 0);
    chk("idle_regwrite", RegWrite, 0);

    // Single ALU write to reg 8
    Alu_Valid = 1'b1; Alu_Register = 5'd8; Alu_Data = 32'hAA;
    Lookup_Register = 5'd8;
    #1;
    chk("single_pre_hit", Lookup_Hit, 0);
    tick();
    idle_inputs();
    #1;
    chk("single_n_hit", Lookup_Hit, 1);
    chk("single_n_data", Lookup_Data, 32'hAA);
    chk("single_n_count", Count, 1);
    chk("single_n_regwrite", RegWrite, 0);
    tick();
    chk("single_n1_regwrite", RegWrite, 1);
    chk("single_n1_wreg", Write_Register, 8);
    chk("single_n1_wdata", Write_Data, 32'hAA);
    chk("single_n1_count", Count, 0);
    chk("single_n1_hit", Lookup_Hit, 1);
    chk("single_n1_empty", Empty, 0);
    tick();
    chk("single_n2_regwrite", RegWrite, 0);
    chk("single_n2_empty", Empty, 1);
    chk("single_n2_hit", Lookup_Hit, 0);
    chk("single_n2_wreg_hold", Write_Register, 8);

    // Dual enqueue to the same register: Mem is older
    Mem_Valid = 1'b1; Mem_Register = 5'd3; Mem_Data = 32'h11;
    Alu_Valid = 1'b1; Alu_Register = 5'd3; Alu_Data = 32'h22;
    Lookup_Register = 5'd3;
    #1;
    chk("dual_mem_ready", Mem_Ready, 1);
    chk("dual_alu_ready", Alu_Ready, 1);
    tick();
    idle_inputs();
    #1;
    chk("dual_count", Count, 2);
    chk("dual_lookup0", Lookup_Data, 32'h22);
    tick();
    chk("dual_w1_rw", RegWrite, 1);
    chk("dual_w1_data", Write_Data, 32'h11);
    chk("dual_lookup1", Lookup_Data, 32'h22);
    tick();
    chk("dual_w2_rw", RegWrite, 1);
    chk("dual_w2_data", Write_Data, 32'h22);
    chk("dual_w2_reg", Write_Register, 3);
    chk("dual_lookup2", Lookup_Data, 32'h22);
    tick();
    chk("dual_done_rw", RegWrite, 0);
    chk("dual_done_hit", Lookup_Hit, 0);

    // Backpressure: Mem offers odd regs 1..9, ALU even regs 2..10; each holds until accepted
    mcount = 0; m_idx = 0; a_idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      Mem_Valid    = (m_idx < 5);
      Mem_Register = 5'(1 + 2 * m_idx);
      Mem_Data     = 32'h100 + 32'(1 + 2 * m_idx);
      Alu_Valid    = (a_idx < 5);
      Alu_Register = 5'(2 + 2 * a_idx);
      Alu_Data     = 32'h100 + 32'(2 + 2 * a_idx);
      #1;
      macc = Mem_Valid && (mcount < 4);
      aacc = Alu_Valid && (Mem_Valid ? (mcount <= 2) : (mcount < 4));
      chk("bp_count", Count, mcount);
      chk("bp_count_max", (Count <= 3'd4), 1);
      chk("bp_mem_ready", Mem_Ready, (mcount < 4));
      chk("bp_alu_ready", Alu_Ready, (Mem_Valid ? (mcount <= 2) : (mcount < 4)));
      if (macc) begin q_reg.push_back(Mem_Register); q_data.push_back(Mem_Data); end
      if (aacc) begin q_reg.push_back(Alu_Register); q_data.push_back(Alu_Data); end
      tick();
      exp_rw = (mcount > 0);
      if (exp_rw) begin
        exp_wr = q_reg.pop_front();
        exp_wd = q_data.pop_front();
      end
      mcount = mcount + int'(macc) + int'(aacc) - int'(exp_rw);
      if (macc) m_idx++;
      if (aacc) a_idx++;
      chk("bp_regwrite", RegWrite, exp_rw);
      if (exp_rw) begin
        chk("bp_wreg", Write_Register, exp_wr);
        chk("bp_wdata", Write_Data, exp_wd);
      end
    end
    idle_inputs();
    chk("bp_all_mem_taken", m_idx, 5);
    chk("bp_all_alu_taken", a_idx, 5);

    // Register 0 from ALU alone: handshake only
    Alu_Valid = 1'b1; Alu_Register = 5'd0; Alu_Data = 32'hFFFF_FFFF;
    Lookup_Register = 5'd0;
    #1;
    chk("r0_alu_ready", Alu_Ready, 1);
    chk("r0_lookup_hit", Lookup_Hit, 0);
    tick();
    idle_inputs();
    #1;
    chk("r0_count", Count, 0);
    chk("r0_lookup_hit_after", Lookup_Hit, 0);
    chk("r0_lookup_data", Lookup_Data, 0);
    tick();
    chk("r0_no_regwrite", RegWrite, 0);

    // Mem to reg 0 with ALU to reg 9: ALU lands at tail and is the only entry
    Mem_Valid = 1'b1; Mem_Register = 5'd0; Mem_Data = 32'hDEAD;
    Alu_Valid = 1'b1; Alu_Register = 5'd9; Alu_Data = 32'h99;
    Lookup_Register = 5'd9;
    tick();
    idle_inputs();
    #1;
    chk("r0mix_count", Count, 1);
    chk("r0mix_lookup", Lookup_Data, 32'h99);
    tick();
    chk("r0mix_wreg", Write_Register, 9);
    chk("r0mix_wdata", Write_Data, 32'h99);
    tick();
    chk("r0mix_done", RegWrite, 0);

    // Reset mid-drain
    Mem_Valid = 1'b1; Mem_Register = 5'd11; Mem_Data = 32'hA1;
    Alu_Valid = 1'b1; Alu_Register = 5'd12; Alu_Data = 32'hA2;
    tick();
    Alu_Valid = 1'b0;
    Mem_Register = 5'd13; Mem_Data = 32'hA3;
    tick();
    idle_inputs();
    Lookup_Register = 5'd13;
    #1;
    chk("mid_pre_regwrite", RegWrite, 1);
    chk("mid_pre_count", Count, 2);
    chk("mid_pre_hit", Lookup_Hit, 1);
    Reset_n = 1'b0;
    Mem_Valid = 1'b1; Mem_Register = 5'd14; Mem_Data = 32'hA4;
    tick();
    Reset_n = 1'b1;
    idle_inputs();
    #1;
    chk("mid_regwrite", RegWrite, 0);
    chk("mid_count", Count, 0);
    chk("mid_wreg", Write_Register, 0);
    chk("mid_empty", Empty, 1);
    chk("mid_hit", Lookup_Hit, 0);
    tick();
    chk("mid_after1_rw", RegWrite, 0);
    tick();
    chk("mid_after2_rw", RegWrite, 0);
    chk("mid_after2_count", Count, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
